// File: rtl/dlx_execute_stage.sv
// dlx_execute_stage: execute stage of the DLX ALU pipeline.
// Arithmetic and logic ops finish in one registered cycle. Shifts run on a
// serial shifter that moves one bit per cycle, and busy stalls the issuing
// stage while that shifter is running.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | ready; a request is sampled at every rising edge
//   ST_SHIFT | serial shift in flight; busy=1, incoming requests ignored
module dlx_execute_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter logic [2:0]  ARITH_SEL = 3'b001,
  parameter logic [2:0]  SHIFT_SEL = 3'b000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         aluin1,
  input  logic [WIDTH-1:0]         aluin2,
  input  logic [2:0]               operation,
  input  logic [2:0]               opselect,
  input  logic [$clog2(WIDTH)-1:0] shift_number,
  input  logic                     enable_arith,
  input  logic                     enable_shift,
  output logic [WIDTH-1:0]         aluout,
  output logic                     carry,
  output logic                     overflow,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     illegal
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       shop_q, shop_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             ill_q, ill_d;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] arith_res;
  logic             arith_c, arith_v;
  logic             slt_bit;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  // Single-cycle arithmetic/logic unit, evaluated on the live bus operands.
  always_comb begin
    add_sum   = {1'b0, aluin1} + {1'b0, aluin2};
    sub_sum   = {1'b0, aluin1} + {1'b0, ~aluin2} + {{WIDTH{1'b0}}, 1'b1};
    slt_bit   = $signed(aluin1) < $signed(aluin2);
    arith_res = '0;
    arith_c   = 1'b0;
    arith_v   = 1'b0;
    case (operation)
      3'b000: begin
        arith_res = add_sum[WIDTH-1:0];
        arith_c   = add_sum[WIDTH];
        // Same-sign operands producing a result of the other sign.
        arith_v   = (aluin1[WIDTH-1] == aluin2[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != aluin1[WIDTH-1]);
      end
      3'b001: begin
        arith_res = sub_sum[WIDTH-1:0];
        arith_c   = sub_sum[WIDTH];
        arith_v   = (aluin1[WIDTH-1] != aluin2[WIDTH-1]) &&
                    (sub_sum[WIDTH-1] != aluin1[WIDTH-1]);
      end
      3'b010:  arith_res = aluin1 & aluin2;
      3'b011:  arith_res = aluin1 | aluin2;
      3'b100:  arith_res = aluin1 ^ aluin2;
      3'b101:  arith_res = ~aluin1;
      3'b110:  arith_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: arith_res = aluin2;
    endcase
  end

  // One step of the serial shifter: the next accumulator value and the bit
  // that leaves it (for ROL, the bit that wraps into the LSB).
  always_comb begin
    step_val = acc_q;
    step_bit = 1'b0;
    case (shop_q)
      2'b00: begin
        step_val = {acc_q[WIDTH-2:0], 1'b0};
        step_bit = acc_q[WIDTH-1];
      end
      2'b01: begin
        step_val = {1'b0, acc_q[WIDTH-1:1]};
        step_bit = acc_q[0];
      end
      2'b10: begin
        step_val = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        step_bit = acc_q[0];
      end
      default: begin
        step_val = {acc_q[WIDTH-2:0], acc_q[WIDTH-1]};
        step_bit = acc_q[WIDTH-1];
      end
    endcase
  end

  // Next-state and request handling. Result registers hold unless a result
  // is produced, so aluout/flags only move on out_valid cycles.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
    aluout_d = aluout_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    ill_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_arith) begin
          // Arithmetic wins when both strobes are high.
          if (opselect == ARITH_SEL) begin
            aluout_d = arith_res;
            carry_d  = arith_c;
            ovf_d    = arith_v;
            valid_d  = 1'b1;
          end else begin
            ill_d = 1'b1;
          end
        end else if (enable_shift) begin
          if (opselect != SHIFT_SEL) begin
            ill_d = 1'b1;
          end else if (shift_number == '0) begin
            // A zero-distance shift is a pass-through and never goes busy.
            aluout_d = aluin1;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            valid_d  = 1'b1;
          end else begin
            acc_d   = aluin1;
            cnt_d   = shift_number;
            shop_d  = operation[1:0];
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = step_val;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          aluout_d = step_val;
          carry_d  = step_bit;
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset; reset also aborts
  // any shift in flight without producing a result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      shop_q   <= 2'b00;
      aluout_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shop_q   <= shop_d;
      aluout_q <= aluout_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      ill_q    <= ill_d;
    end
  end

  assign aluout    = aluout_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign out_valid = valid_q;
  assign illegal   = ill_q;
  assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_dlx_execute_stage.sv
// Testbench for dlx_execute_stage: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_dlx_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] aluin1, aluin2;
  logic [2:0]  operation, opselect;
  logic [4:0]  shift_number;
  logic        enable_arith, enable_shift;
  logic [31:0] aluout;
  logic        carry, overflow, out_valid, busy, illegal;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  dlx_execute_stage #(.WIDTH(32), .ARITH_SEL(3'b001), .SHIFT_SEL(3'b000)) dut (
    .clk(clk), .rst(rst), .aluin1(aluin1), .aluin2(aluin2),
    .operation(operation), .opselect(opselect), .shift_number(shift_number),
    .enable_arith(enable_arith), .enable_shift(enable_shift),
    .aluout(aluout), .carry(carry), .overflow(overflow),
    .out_valid(out_valid), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Behavioural model: a shift is a countdown of remaining busy cycles with
  // its final result computed up front using whole-word operators.
  logic [31:0] m_out = '0, p_out = '0;
  logic        m_c = 1'b0, m_o = 1'b0, m_v = 1'b0, m_ill = 1'b0, p_c = 1'b0;
  int          m_left = 0;

  always @(posedge clk) begin
    longint sa, sb, sr;
    longint unsigned ua, ub;
    int n;
    if (rst) begin
      m_out = '0; m_c = 1'b0; m_o = 1'b0; m_v = 1'b0; m_ill = 1'b0; m_left = 0;
    end else begin
      m_v = 1'b0; m_ill = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_out = p_out; m_c = p_c; m_o = 1'b0; m_v = 1'b1;
        end
      end else if (enable_arith) begin
        if (opselect != 3'b001) m_ill = 1'b1;
        else begin
          m_v = 1'b1; m_c = 1'b0; m_o = 1'b0;
          sa = longint'($signed(aluin1)); sb = longint'($signed(aluin2));
          ua = longint'(aluin1); ub = longint'(aluin2);
          case (operation)
            3'd0: begin
              m_out = aluin1 + aluin2;
              m_c   = (ua + ub) >= 64'h1_0000_0000;
              sr    = sa + sb;
              m_o   = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
            end
            3'd1: begin
              m_out = aluin1 - aluin2;
              m_c   = (ua >= ub);
              sr    = sa - sb;
              m_o   = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
            end
            3'd2: m_out = aluin1 & aluin2;
            3'd3: m_out = aluin1 | aluin2;
            3'd4: m_out = aluin1 ^ aluin2;
            3'd5: m_out = ~aluin1;
            3'd6: m_out = (sa < sb) ? 32'd1 : 32'd0;
            default: m_out = aluin2;
          endcase
        end
      end else if (enable_shift) begin
        if (opselect != 3'b000) m_ill = 1'b1;
        else if (shift_number == 5'd0) begin
          m_out = aluin1; m_c = 1'b0; m_o = 1'b0; m_v = 1'b1;
        end else begin
          n = int'(shift_number);
          m_left = n;
          case (operation[1:0])
            2'd0: begin p_out = aluin1 << n; p_c = aluin1[32-n]; end
            2'd1: begin p_out = aluin1 >> n; p_c = aluin1[n-1]; end
            2'd2: begin p_out = 32'($signed(aluin1) >>> n); p_c = aluin1[n-1]; end
            default: begin p_out = (aluin1 << n) | (aluin1 >> (32 - n)); p_c = aluin1[32-n]; end
          endcase
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_aluout", aluout, m_out);
      chk("m_carry", 32'(carry), 32'(m_c));
      chk("m_overflow", 32'(overflow), 32'(m_o));
      chk("m_out_valid", 32'(out_valid), 32'(m_v));
      chk("m_busy", 32'(busy), 32'(m_left > 0));
      chk("m_illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit ea, input bit es, input logic [2:0] op,
                       input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] n);
    enable_arith = ea; enable_shift = es; operation = op; opselect = sel;
    aluin1 = a; aluin2 = b; shift_number = n;
  endtask

  task automatic quiet();
    enable_arith = 1'b0; enable_shift = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    drive(0, 0, 3'd0, 3'd0, 32'd0, 32'd0, 5'd0);
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_aluout", aluout, 32'd0);
    chk("rst_flags", {26'd0, carry, overflow, out_valid, busy, illegal, 1'b0}, 32'd0);
    rst = 1'b0;

    // ADD wrap to zero with carry out.
    drive(1, 0, 3'b000, 3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    tick();
    chk("add_out", aluout, 32'd0);
    chk("add_cv", {30'd0, carry, overflow}, 32'd2);
    chk("add_valid", 32'(out_valid), 32'd1);
    quiet();
    tick();
    chk("add_valid_drop", 32'(out_valid), 32'd0);
    chk("add_hold", aluout, 32'd0);

    // Back-to-back SUB and SLT.
    drive(1, 0, 3'b001, 3'b001, 32'h8000_0000, 32'h0000_0001, 5'd0);
    tick();
    chk("sub_out", aluout, 32'h7FFF_FFFF);
    chk("sub_cv", {30'd0, carry, overflow}, 32'd3);
    chk("sub_valid", 32'(out_valid), 32'd1);
    drive(1, 0, 3'b110, 3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
    tick();
    chk("slt_out", aluout, 32'd1);
    chk("slt_cv", {30'd0, carry, overflow}, 32'd0);
    chk("slt_valid", 32'(out_valid), 32'd1);
    quiet();
    tick();

    // SRA by 4 with a conflicting ADD held during busy.
    drive(0, 1, 3'b010, 3'b000, 32'h8000_0001, 32'd0, 5'd4);
    tick();
    drive(1, 0, 3'b000, 3'b001, 32'h1, 32'h1, 5'd0);
    chk("sra_busy1", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sra_busy", {30'd0, busy, out_valid}, 32'd2);
    end
    tick();
    chk("sra_done", {30'd0, busy, out_valid}, 32'd1);
    chk("sra_out", aluout, 32'hF800_0000);
    chk("sra_carry", 32'(carry), 32'd0);
    quiet();
    tick();
    chk("sra_pulse", 32'(out_valid), 32'd0);
    chk("sra_hold", aluout, 32'hF800_0000);

    // ROL by 1, then SLL by 0.
    drive(0, 1, 3'b011, 3'b000, 32'h8000_0000, 32'd0, 5'd1);
    tick();
    chk("rol_busy", 32'(busy), 32'd1);
    quiet();
    tick();
    chk("rol_out", aluout, 32'h0000_0001);
    chk("rol_carry", 32'(carry), 32'd1);
    chk("rol_done", {30'd0, busy, out_valid}, 32'd1);
    drive(0, 1, 3'b000, 3'b000, 32'h0000_1234, 32'd0, 5'd0);
    tick();
    chk("sll0_out", aluout, 32'h0000_1234);
    chk("sll0_flags", {30'd0, busy, out_valid}, 32'd1);
    quiet();
    tick();

    // Illegal select, then both strobes with arithmetic select.
    drive(1, 0, 3'b000, 3'b000, 32'h5, 32'h6, 5'd0);
    tick();
    chk("ill_pulse", {30'd0, illegal, out_valid}, 32'd2);
    chk("ill_hold", aluout, 32'h0000_1234);
    quiet();
    tick();
    chk("ill_drop", 32'(illegal), 32'd0);
    drive(1, 1, 3'b111, 3'b001, 32'h1, 32'h0000_ABCD, 5'd3);
    tick();
    chk("both_out", aluout, 32'h0000_ABCD);
    chk("both_flags", {30'd0, busy, out_valid}, 32'd1);
    quiet();
    tick();

    // Reset during a long SLL.
    drive(0, 1, 3'b000, 3'b000, 32'h1, 32'd0, 5'd31);
    tick();
    quiet();
    for (int i = 0; i < 9; i++) tick();
    chk("sll31_busy10", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_out", aluout, 32'd0);
    chk("abort_flags", {27'd0, carry, overflow, out_valid, busy, illegal}, 32'd0);
    rst = 1'b0;
    tick();
    drive(1, 0, 3'b000, 3'b001, 32'd5, 32'd7, 5'd0);
    tick();
    chk("post_rst_add", aluout, 32'd12);
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    quiet();
    tick();

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      enable_arith = ($urandom_range(0, 2) == 0);
      enable_shift = ($urandom_range(0, 1) == 0);
      operation = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: opselect = 3'b000;
        1: opselect = 3'b001;
        default: opselect = 3'($urandom_range(0, 7));
      endcase
      aluin1 = pick_operand();
      aluin2 = pick_operand();
      shift_number = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3))
                                                 : 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0;
    quiet();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
